// File: rtl/rom_ctrl_pkg.sv
// Shared types and defaults for the burst ROM arbiter slice.
// Holds the controller state encoding and the burst length helper.
package rom_ctrl_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefLenWidth  = 4;

  // The length field encodes beats-1.
  function automatic int unsigned beat_count(input int unsigned len);
    return len + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above the pointer and wraps,
// returning a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ID_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Requesters above the last winner go first, then the search wraps to the bottom.
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (j > int'(ptr))) begin
        gnt[j] = 1'b1;
        idx    = ID_WIDTH'(j);
        any    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (j <= int'(ptr))) begin
        gnt[j] = 1'b1;
        idx    = ID_WIDTH'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one combinational ROM between several burst readers. A round-robin winner is served
// one beat per cycle through a registered response channel with back-pressure.
module rom_burst_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned LEN_WIDTH  = DefLenWidth,
  parameter int unsigned ID_WIDTH   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0]           rom_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ID_WIDTH-1:0]             rsp_id,
  output logic                            rsp_last,
  output logic                            busy
);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic                  rsp_last_q, rsp_last_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  gnt_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  beat;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // The output register is free when empty or being drained this cycle.
  assign beat = (state_q == StBurst) && (!rsp_valid_q || rsp_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_last_d  = rsp_last_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          addr_d  = sel_addr;
          cnt_d   = sel_len;
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (beat) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rom_data;
          rsp_id_d    = id_q;
          rsp_last_d  = (cnt_q == '0);
          addr_d      = addr_q + 1'b1;
          cnt_d       = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= ID_WIDTH'(NUM_REQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  // Accept is blocked while reset is held so the strobe never promises a lost transfer.
  assign req_ready = ((state_q == StIdle) && !rst) ? gnt : '0;
  assign rom_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = (state_q == StBurst);

endmodule
